branch_target_pc_unit: RTL and testbench
========================================

Name: branch_target_pc_unit

Overview:
- Program-counter stage that consumes the shift-left-2 output (sign-extended branch offset << 2) and produces the next fetch address.
- Holds the PC register and computes PC+4, branch, jump and jump-register targets.
- Latches redirects that resolve while the pipeline is stalled, flags misaligned register jumps, and counts PC advances for debug.
- Sits between the shift-left-2/sign-extend path and instruction fetch.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- Clk  in  1  system clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- Stall  in  1  hold PC this cycle.
- BranchEq  in  1  beq decoded.
- BranchNe  in  1  bne decoded.
- AluZero  in  1  ALU zero flag for the current branch.
- Jump  in  1  j/jal decoded.
- JumpReg  in  1  jr decoded.
- ShiftedImm  in  32  shift-left-2 output; bits [1:0] ignored (treated as 00).
- JumpIndex  in  26  instruction bits [25:0].
- RegTarget  in  32  register operand for jr.
- PC  out  32  current fetch address, registered.
- PCPlus4  out  32  PC + 4, combinational, wraps mod 2^32.
- BranchTarget  out  32  PCPlus4 + {ShiftedImm[31:2],2'b00}, combinational, wraps mod 2^32.
- Redirect  out  1  registered one-cycle pulse; the PC was loaded with a non-sequential target on the previous edge.
- MisalignErr  out  1  sticky; a jr target had [1:0] != 0.
- AdvanceCount  out  32  number of PC updates since reset; wraps.

Behaviour:
- Reset: synchronous, highest priority over all inputs and states.
  - PC=RESET_PC, Redirect=0, MisalignErr=0, AdvanceCount=0, PendingPC=0, state=RUN.
- Branch taken = (BranchEq & AluZero) | (BranchNe & ~AluZero). Both asserted together is an unconditional branch.
- Jump target = {PCPlus4[31:28], JumpIndex, 2'b00}.
- Next-target priority: JumpReg > Jump > taken branch > PCPlus4. "Redirect request" means any of the first three.
- FSM states: RUN, HOLD, FAULT.
- RUN:
  - JumpReg=1 and RegTarget[1:0]!=0 (regardless of Stall): MisalignErr<=1, PC unchanged, go FAULT.
  - Stall=0: PC<=next target; AdvanceCount+=1; Redirect<=1 if the target came from a redirect request, else 0.
  - Stall=1 with redirect request: PendingPC<=selected target, PC held, go HOLD, Redirect<=0.
  - Stall=1 without redirect request: PC held, Redirect<=0, stay RUN.
- HOLD:
  - PC held. All control inputs are ignored; the stalled instruction already resolved.
  - On Stall=0: PC<=PendingPC, AdvanceCount+=1, Redirect<=1, go RUN.
- FAULT:
  - PC and AdvanceCount frozen, Redirect=0, MisalignErr=1.
  - Only Reset exits.
- Latency: one edge from a RUN request to PC update. Redirect asserts in the same cycle the new PC is visible.
- Wrap: PC=32'hFFFF_FFFC gives PCPlus4=0. Branch arithmetic discards the carry.
- Reset during HOLD discards PendingPC.

Decomposition:
- Shared package (cpu_pkg): state encoding for RUN/HOLD/FAULT; constant PC_INCR=4.
- One sub-module, pc_target_select: purely combinational. Computes PCPlus4, BranchTarget, jump target, taken flag, next target and redirect-request flag.
- Top level holds the FSM, PC, PendingPC, counter and flags.

Test Plan:
1. RESET_PC=32'h0040_0000, Reset for 1 cycle, then 3 free cycles -> PC sequence 0x00400000, 0x00400004, 0x00400008, 0x0040000C; AdvanceCount=3; Redirect=0 throughout.
2. Taken branch: PC=0x00400010, BranchEq=1, AluZero=1, ShiftedImm=0xFFFFFFF0 -> PC=0x00400004 and Redirect=1 for exactly one cycle.
   - Same setup with BranchNe=1, AluZero=1 (not taken) -> PC=0x00400014, Redirect=0.
3. Jump: PC=0x00400008, Jump=1, JumpIndex=26'h0100020 -> PC=0x00400080, Redirect=1.
   - Jump and taken branch asserted together -> jump target wins.
4. Stalled branch: taken branch to 0x00400100 with Stall=1 for 3 cycles, and a different Jump asserted in cycle 2 -> PC held, AdvanceCount unchanged.
   - After Stall falls: PC=0x00400100, AdvanceCount+1, single Redirect pulse.
5. Misaligned jr: JumpReg=1, RegTarget=0x00400102 -> MisalignErr=1 and PC frozen; later Jump and branch inputs have no effect.
   - Reset -> MisalignErr=0, PC=RESET_PC.
6. Boundaries:
   - PC=0xFFFFFFFC with no control -> PC=0x00000000.
   - Reset asserted while in HOLD -> PC=RESET_PC, state RUN; releasing Stall afterwards does not load the old PendingPC.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and constants for the PC stage: FSM encoding and the bundle
// of targets produced by the combinational selector.
package cpu_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HOLD  = 2'd1,
        ST_FAULT = 2'd2
    } pc_state_e;

    localparam logic [31:0] PC_INCR = 32'd4;

    typedef struct packed {
        logic [31:0] pc_plus4;
        logic [31:0] branch_target;
        logic [31:0] next_pc;
        logic        redir_req;
    } tgt_sel_t;

endpackage

// File: rtl/pc_target_select.sv
// Combinational next-PC selection: sequential, branch, jump and jr targets,
// resolved with priority jr > j > taken branch > PC+4.
module pc_target_select
    import cpu_pkg::*;
(
    input  logic [31:0] pc,
    input  logic        branch_eq,
    input  logic        branch_ne,
    input  logic        alu_zero,
    input  logic        jump,
    input  logic        jump_reg,
    input  logic [31:0] shifted_imm,
    input  logic [25:0] jump_index,
    input  logic [31:0] reg_target,
    output tgt_sel_t    sel
);

    logic [31:0] pc_plus4;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic        taken;
    logic        unused_imm_lsb;

    // Low offset bits are forced to zero rather than trusted from upstream.
    assign unused_imm_lsb = ^shifted_imm[1:0];

    assign pc_plus4      = pc + PC_INCR;
    assign branch_target = pc_plus4 + {shifted_imm[31:2], 2'b00};
    assign jump_target   = {pc_plus4[31:28], jump_index, 2'b00};
    assign taken         = (branch_eq & alu_zero) | (branch_ne & ~alu_zero);

    always_comb begin
        sel.pc_plus4      = pc_plus4;
        sel.branch_target = branch_target;
        sel.redir_req     = jump_reg | jump | taken;
        if (jump_reg)
            sel.next_pc = reg_target;
        else if (jump)
            sel.next_pc = jump_target;
        else if (taken)
            sel.next_pc = branch_target;
        else
            sel.next_pc = pc_plus4;
    end

endmodule

// File: rtl/branch_target_pc_unit.sv
// PC register stage: applies the selected next target, parks redirects that
// resolve under stall, traps misaligned jr and counts PC advances.
module branch_target_pc_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Stall,
    input  logic        BranchEq,
    input  logic        BranchNe,
    input  logic        AluZero,
    input  logic        Jump,
    input  logic        JumpReg,
    input  logic [31:0] ShiftedImm,
    input  logic [25:0] JumpIndex,
    input  logic [31:0] RegTarget,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic [31:0] BranchTarget,
    output logic        Redirect,
    output logic        MisalignErr,
    output logic [31:0] AdvanceCount
);

    pc_state_e   state_q, state_d;
    tgt_sel_t    sel;
    logic [31:0] pc_q, pending_q, count_q, pc_d;
    logic        redirect_q, misalign_q;
    logic        misalign, pc_load, pend_load, redir_d, fault_set;

    pc_target_select u_sel (
        .pc          (pc_q),
        .branch_eq   (BranchEq),
        .branch_ne   (BranchNe),
        .alu_zero    (AluZero),
        .jump        (Jump),
        .jump_reg    (JumpReg),
        .shifted_imm (ShiftedImm),
        .jump_index  (JumpIndex),
        .reg_target  (RegTarget),
        .sel         (sel)
    );

    assign misalign = JumpReg && (RegTarget[1:0] != 2'b00);

    always_ff @(posedge Clk) begin
        if (Reset) state_q <= ST_RUN;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (misalign)                    state_d = ST_FAULT;
                else if (Stall && sel.redir_req) state_d = ST_HOLD;
            end
            ST_HOLD: if (!Stall) state_d = ST_RUN;
            default: state_d = ST_FAULT;
        endcase
    end

    always_comb begin
        pc_load   = 1'b0;
        pc_d      = pc_q;
        pend_load = 1'b0;
        redir_d   = 1'b0;
        fault_set = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (misalign) begin
                    fault_set = 1'b1;
                end else if (!Stall) begin
                    pc_load = 1'b1;
                    pc_d    = sel.next_pc;
                    redir_d = sel.redir_req;
                end else begin
                    pend_load = sel.redir_req;
                end
            end
            // Controls are ignored here; the parked target is already resolved.
            ST_HOLD: begin
                if (!Stall) begin
                    pc_load = 1'b1;
                    pc_d    = pending_q;
                    redir_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            pc_q       <= RESET_PC;
            pending_q  <= '0;
            count_q    <= '0;
            redirect_q <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            if (pc_load) begin
                pc_q    <= pc_d;
                count_q <= count_q + 32'd1;
            end
            if (pend_load) pending_q <= sel.next_pc;
            redirect_q <= redir_d;
            misalign_q <= misalign_q | fault_set;
        end
    end

    assign PC           = pc_q;
    assign PCPlus4      = sel.pc_plus4;
    assign BranchTarget = sel.branch_target;
    assign Redirect     = redirect_q;
    assign MisalignErr  = misalign_q;
    assign AdvanceCount = count_q;

endmodule

// File: tb/tb_branch_target_pc_unit.sv
// Directed bench for branch_target_pc_unit with hand-computed expectations.
module tb_branch_target_pc_unit;

    localparam logic [31:0] RST_PC = 32'h0040_0000;

    logic        Clk = 1'b0;
    logic        Reset, Stall, BranchEq, BranchNe, AluZero, Jump, JumpReg;
    logic [31:0] ShiftedImm, RegTarget;
    logic [25:0] JumpIndex;
    logic [31:0] PC, PCPlus4, BranchTarget, AdvanceCount;
    logic        Redirect, MisalignErr;

    int vecs = 0;
    int errs = 0;

    branch_target_pc_unit #(.RESET_PC(RST_PC)) dut (
        .Clk(Clk), .Reset(Reset), .Stall(Stall), .BranchEq(BranchEq),
        .BranchNe(BranchNe), .AluZero(AluZero), .Jump(Jump), .JumpReg(JumpReg),
        .ShiftedImm(ShiftedImm), .JumpIndex(JumpIndex), .RegTarget(RegTarget),
        .PC(PC), .PCPlus4(PCPlus4), .BranchTarget(BranchTarget),
        .Redirect(Redirect), .MisalignErr(MisalignErr), .AdvanceCount(AdvanceCount)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic clr_inputs();
        Stall = 0; BranchEq = 0; BranchNe = 0; AluZero = 0; Jump = 0; JumpReg = 0;
        ShiftedImm = '0; JumpIndex = '0; RegTarget = '0;
    endtask

    task automatic do_reset();
        clr_inputs();
        Reset = 1;
        tick();
        Reset = 0;
    endtask

    // Moves PC to an address in the current 256 MB region via a j.
    task automatic goto_pc(input logic [31:0] addr);
        Jump = 1; JumpIndex = addr[27:2];
        tick();
        Jump = 0; JumpIndex = '0;
    endtask

    task automatic test_reset_seq();
        clr_inputs();
        Reset = 1;
        tick();
        Reset = 0;
        vecs++; if (PC !== RST_PC) begin errs++; $display("FAIL reset_pc got %h exp %h", PC, RST_PC); end
        vecs++; if (AdvanceCount !== 0) begin errs++; $display("FAIL reset_cnt got %0d exp 0", AdvanceCount); end
        vecs++; if ({Redirect, MisalignErr} !== 2'b00) begin errs++; $display("FAIL reset_flags got %b exp 00", {Redirect, MisalignErr}); end
        for (int i = 1; i <= 3; i++) begin
            tick();
            vecs++; if (PC !== RST_PC + 32'(4*i) || Redirect !== 1'b0) begin
                errs++; $display("FAIL seq%0d got pc=%h redir=%b exp pc=%h redir=0", i, PC, Redirect, RST_PC + 32'(4*i));
            end
        end
        vecs++; if (AdvanceCount !== 3) begin errs++; $display("FAIL seq_cnt got %0d exp 3", AdvanceCount); end
    endtask

    task automatic test_branch();
        do_reset();
        goto_pc(32'h0040_0010);
        BranchEq = 1; AluZero = 1; ShiftedImm = 32'hFFFF_FFF0;
        #1;
        vecs++; if (BranchTarget !== 32'h0040_0004) begin errs++; $display("FAIL br_target_comb got %h exp 00400004", BranchTarget); end
        tick();
        clr_inputs();
        vecs++; if (PC !== 32'h0040_0004 || Redirect !== 1'b1) begin
            errs++; $display("FAIL br_taken got pc=%h redir=%b exp pc=00400004 redir=1", PC, Redirect);
        end
        tick();
        vecs++; if (PC !== 32'h0040_0008 || Redirect !== 1'b0) begin
            errs++; $display("FAIL br_pulse got pc=%h redir=%b exp pc=00400008 redir=0", PC, Redirect);
        end
        goto_pc(32'h0040_0010);
        BranchNe = 1; AluZero = 1; ShiftedImm = 32'hFFFF_FFF0;
        tick();
        clr_inputs();
        vecs++; if (PC !== 32'h0040_0014 || Redirect !== 1'b0) begin
            errs++; $display("FAIL br_not_taken got pc=%h redir=%b exp pc=00400014 redir=0", PC, Redirect);
        end
    endtask

    task automatic test_jump();
        do_reset();
        goto_pc(32'h0040_0008);
        Jump = 1; JumpIndex = 26'h010_0020;
        tick();
        clr_inputs();
        vecs++; if (PC !== 32'h0040_0080 || Redirect !== 1'b1) begin
            errs++; $display("FAIL jump got pc=%h redir=%b exp pc=00400080 redir=1", PC, Redirect);
        end
        Jump = 1; JumpIndex = 26'h010_0040; BranchEq = 1; AluZero = 1; ShiftedImm = 32'h10;
        tick();
        clr_inputs();
        vecs++; if (PC !== 32'h0040_0100) begin errs++; $display("FAIL jump_over_branch got %h exp 00400100", PC); end
    endtask

    task automatic test_stall_redirect();
        do_reset();
        Stall = 1; BranchEq = 1; AluZero = 1; ShiftedImm = 32'h0000_00FC;
        tick();
        BranchEq = 0; AluZero = 0; ShiftedImm = '0;
        Jump = 1; JumpIndex = 26'h010_0200;
        tick();
        Jump = 0; JumpIndex = '0;
        tick();
        vecs++; if (PC !== RST_PC || AdvanceCount !== 0 || Redirect !== 1'b0) begin
            errs++; $display("FAIL stall_hold got pc=%h cnt=%0d redir=%b exp pc=%h cnt=0 redir=0", PC, AdvanceCount, Redirect, RST_PC);
        end
        Stall = 0;
        tick();
        vecs++; if (PC !== 32'h0040_0100 || AdvanceCount !== 1 || Redirect !== 1'b1) begin
            errs++; $display("FAIL stall_release got pc=%h cnt=%0d redir=%b exp pc=00400100 cnt=1 redir=1", PC, AdvanceCount, Redirect);
        end
        tick();
        vecs++; if (PC !== 32'h0040_0104 || AdvanceCount !== 2 || Redirect !== 1'b0) begin
            errs++; $display("FAIL stall_after got pc=%h cnt=%0d redir=%b exp pc=00400104 cnt=2 redir=0", PC, AdvanceCount, Redirect);
        end
    endtask

    task automatic test_misalign();
        do_reset();
        JumpReg = 1; RegTarget = 32'h0040_0102;
        tick();
        clr_inputs();
        vecs++; if (MisalignErr !== 1'b1 || PC !== RST_PC || AdvanceCount !== 0) begin
            errs++; $display("FAIL misalign got err=%b pc=%h cnt=%0d exp err=1 pc=%h cnt=0", MisalignErr, PC, AdvanceCount, RST_PC);
        end
        Jump = 1; JumpIndex = 26'h010_0020; BranchEq = 1; AluZero = 1; ShiftedImm = 32'h40;
        tick();
        tick();
        clr_inputs();
        vecs++; if (MisalignErr !== 1'b1 || PC !== RST_PC || AdvanceCount !== 0 || Redirect !== 1'b0) begin
            errs++; $display("FAIL fault_frozen got err=%b pc=%h cnt=%0d redir=%b exp err=1 pc=%h cnt=0 redir=0", MisalignErr, PC, AdvanceCount, Redirect, RST_PC);
        end
        do_reset();
        vecs++; if (MisalignErr !== 1'b0 || PC !== RST_PC) begin
            errs++; $display("FAIL fault_reset got err=%b pc=%h exp err=0 pc=%h", MisalignErr, PC, RST_PC);
        end
        tick();
        vecs++; if (PC !== RST_PC + 32'd4) begin errs++; $display("FAIL fault_exit_run got %h exp %h", PC, RST_PC + 32'd4); end
    endtask

    task automatic test_boundaries();
        do_reset();
        JumpReg = 1; RegTarget = 32'hFFFF_FFFC;
        tick();
        clr_inputs();
        ShiftedImm = 32'h8;
        #1;
        vecs++; if (PC !== 32'hFFFF_FFFC || Redirect !== 1'b1) begin
            errs++; $display("FAIL jr_aligned got pc=%h redir=%b exp pc=fffffffc redir=1", PC, Redirect);
        end
        vecs++; if (PCPlus4 !== 32'h0 || BranchTarget !== 32'h8) begin
            errs++; $display("FAIL wrap_comb got p4=%h bt=%h exp p4=00000000 bt=00000008", PCPlus4, BranchTarget);
        end
        tick();
        clr_inputs();
        vecs++; if (PC !== 32'h0 || Redirect !== 1'b0) begin
            errs++; $display("FAIL wrap_pc got pc=%h redir=%b exp pc=00000000 redir=0", PC, Redirect);
        end
        do_reset();
        Stall = 1; Jump = 1; JumpIndex = 26'h010_0200;
        tick();
        Jump = 0; JumpIndex = '0;
        Reset = 1;
        tick();
        Reset = 0;
        vecs++; if (PC !== RST_PC || AdvanceCount !== 0) begin
            errs++; $display("FAIL hold_reset got pc=%h cnt=%0d exp pc=%h cnt=0", PC, AdvanceCount, RST_PC);
        end
        Stall = 0;
        tick();
        vecs++; if (PC !== RST_PC + 32'd4 || Redirect !== 1'b0) begin
            errs++; $display("FAIL hold_reset_discard got pc=%h redir=%b exp pc=%h redir=0", PC, Redirect, RST_PC + 32'd4);
        end
    endtask

    initial begin
        Reset = 1;
        clr_inputs();
        test_reset_seq();
        test_branch();
        test_jump();
        test_stall_redirect();
        test_misalign();
        test_boundaries();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
